// File: rtl/prog_loader_pkg.sv
// Shared encodings and constants for the program loader / register dumper.
package prog_loader_pkg;

  localparam int NUM_REGS  = 32;
  localparam int XLEN      = 32;
  localparam int RF_ADDR_W = 5;

  localparam logic [2:0] ST_LOAD = 3'd0;
  localparam logic [2:0] ST_HOLD = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_DUMP = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    LOAD = ST_LOAD,
    HOLD = ST_HOLD,
    RUN  = ST_RUN,
    DUMP = ST_DUMP,
    DONE = ST_DONE
  } state_t;

  localparam logic [RF_ADDR_W-1:0] LAST_REG = RF_ADDR_W'(NUM_REGS - 1);

  // Word count to byte address of the first word past the program.
  function automatic logic [XLEN-1:0] word_to_byte(input logic [XLEN-1:0] words);
    return words << 2;
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Streams a program into instruction memory, runs the core until its PC leaves
// the program (or a timeout), then streams the frozen register file out.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int IMEM_DEPTH  = 256,
  parameter int ADDR_W      = 8,
  parameter int RST_HOLD    = 2,
  parameter int RUN_TIMEOUT = 65535
) (
  input  logic                 Clk_Core,
  input  logic                 Rst_Core,
  input  logic [XLEN-1:0]      Load_Data,
  input  logic                 Load_Valid,
  input  logic                 Load_Last,
  output logic                 Load_Ready,
  output logic                 Imem_Wr_En,
  output logic [ADDR_W-1:0]    Imem_Wr_Addr,
  output logic [XLEN-1:0]      Imem_Wr_Data,
  output logic                 Core_Rst_N,
  input  logic [XLEN-1:0]      Core_PC,
  output logic [RF_ADDR_W-1:0] Rf_Rd_Addr,
  input  logic [XLEN-1:0]      Rf_Rd_Data,
  output logic [XLEN-1:0]      Dump_Data,
  output logic                 Dump_Valid,
  output logic                 Dump_Last,
  input  logic                 Dump_Ready,
  output logic                 Done,
  output logic                 Timeout
);

  localparam logic [ADDR_W-1:0]    PTR_FULL   = ADDR_W'(IMEM_DEPTH - 1);
  localparam logic [ADDR_W-1:0]    PTR_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W:0]      CNT_ONE    = (ADDR_W + 1)'(1);
  localparam logic [XLEN-1:0]      TIMER_LAST = XLEN'(RUN_TIMEOUT - 1);
  localparam logic [XLEN-1:0]      HOLD_LAST  = XLEN'(RST_HOLD - 1);
  localparam logic [XLEN-1:0]      XLEN_ONE   = XLEN'(1);
  localparam logic [RF_ADDR_W-1:0] IDX_ONE    = RF_ADDR_W'(1);

  state_t                 state_r;
  logic [ADDR_W-1:0]      wr_ptr_r;
  logic [ADDR_W:0]        count_r;
  logic [XLEN-1:0]        timer_r;
  logic [XLEN-1:0]        hold_cnt_r;
  logic [XLEN-1:0]        target_r;
  logic [RF_ADDR_W-1:0]   idx_r;

  logic                   load_ready_r;
  logic                   imem_wr_en_r;
  logic [ADDR_W-1:0]      imem_wr_addr_r;
  logic [XLEN-1:0]        imem_wr_data_r;
  logic                   core_rst_n_r;
  logic                   dump_valid_r;
  logic                   dump_last_r;
  logic                   done_r;
  logic                   timeout_r;

  logic                   accept_s;
  logic                   load_end_s;
  logic                   pc_hit_s;
  logic                   timer_hit_s;
  logic                   beat_s;

  // Handshake and terminal-condition decode for the sequencer.
  always_comb begin
    accept_s    = Load_Valid & load_ready_r;
    load_end_s  = accept_s & (Load_Last | (wr_ptr_r == PTR_FULL));
    pc_hit_s    = (Core_PC == target_r);
    timer_hit_s = (timer_r == TIMER_LAST);
    beat_s      = dump_valid_r & Dump_Ready;
  end

  // Load / hold / run / dump sequencer with all outputs registered.
  always_ff @(posedge Clk_Core) begin
    if (Rst_Core) begin
      state_r        <= LOAD;
      wr_ptr_r       <= {ADDR_W{1'b0}};
      count_r        <= {(ADDR_W + 1){1'b0}};
      timer_r        <= {XLEN{1'b0}};
      hold_cnt_r     <= {XLEN{1'b0}};
      target_r       <= {XLEN{1'b0}};
      idx_r          <= {RF_ADDR_W{1'b0}};
      load_ready_r   <= 1'b0;
      imem_wr_en_r   <= 1'b0;
      imem_wr_addr_r <= {ADDR_W{1'b0}};
      imem_wr_data_r <= {XLEN{1'b0}};
      core_rst_n_r   <= 1'b0;
      dump_valid_r   <= 1'b0;
      dump_last_r    <= 1'b0;
      done_r         <= 1'b0;
      timeout_r      <= 1'b0;
    end else begin
      case (state_r)
        LOAD: begin
          core_rst_n_r <= 1'b0;
          if (accept_s) begin
            imem_wr_en_r   <= 1'b1;
            imem_wr_addr_r <= wr_ptr_r;
            imem_wr_data_r <= Load_Data;
            count_r        <= count_r + CNT_ONE;
            if (wr_ptr_r != PTR_FULL) begin
              wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
              wr_ptr_r <= wr_ptr_r;
            end
          end else begin
            imem_wr_en_r <= 1'b0;
          end
          if (load_end_s) begin
            state_r      <= HOLD;
            load_ready_r <= 1'b0;
          end else begin
            load_ready_r <= 1'b1;
          end
        end
        HOLD: begin
          // The final write issued by LOAD is on the bus during the first HOLD cycle.
          imem_wr_en_r <= 1'b0;
          load_ready_r <= 1'b0;
          target_r     <= word_to_byte(XLEN'(count_r));
          if (hold_cnt_r >= HOLD_LAST) begin
            state_r      <= RUN;
            hold_cnt_r   <= {XLEN{1'b0}};
            core_rst_n_r <= 1'b1;
          end else begin
            hold_cnt_r   <= hold_cnt_r + XLEN_ONE;
            core_rst_n_r <= 1'b0;
          end
        end
        RUN: begin
          timer_r <= timer_r + XLEN_ONE;
          if (pc_hit_s || timer_hit_s) begin
            // PC match has priority, so Timeout only flags a genuine overrun.
            state_r      <= DUMP;
            core_rst_n_r <= 1'b0;
            dump_valid_r <= 1'b1;
            dump_last_r  <= (LAST_REG == {RF_ADDR_W{1'b0}});
            idx_r        <= {RF_ADDR_W{1'b0}};
            timeout_r    <= ~pc_hit_s;
          end else begin
            core_rst_n_r <= 1'b1;
          end
        end
        DUMP: begin
          core_rst_n_r <= 1'b0;
          if (beat_s) begin
            if (idx_r == LAST_REG) begin
              state_r      <= DONE;
              dump_valid_r <= 1'b0;
              dump_last_r  <= 1'b0;
              done_r       <= 1'b1;
            end else begin
              idx_r       <= idx_r + IDX_ONE;
              dump_last_r <= (idx_r == (LAST_REG - IDX_ONE));
            end
          end else begin
            idx_r <= idx_r;
          end
        end
        DONE: begin
          core_rst_n_r <= 1'b0;
          dump_valid_r <= 1'b0;
          dump_last_r  <= 1'b0;
          done_r       <= 1'b1;
        end
        default: begin
          state_r      <= LOAD;
          load_ready_r <= 1'b0;
          imem_wr_en_r <= 1'b0;
          core_rst_n_r <= 1'b0;
          dump_valid_r <= 1'b0;
          dump_last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign Load_Ready   = load_ready_r;
  assign Imem_Wr_En   = imem_wr_en_r;
  assign Imem_Wr_Addr = imem_wr_addr_r;
  assign Imem_Wr_Data = imem_wr_data_r;
  assign Core_Rst_N   = core_rst_n_r;
  assign Rf_Rd_Addr   = idx_r;
  // Register file read is combinational from the registered index, so data holds with idx.
  assign Dump_Data    = dump_valid_r ? Rf_Rd_Data : {XLEN{1'b0}};
  assign Dump_Valid   = dump_valid_r;
  assign Dump_Last    = dump_last_r;
  assign Done         = done_r;
  assign Timeout      = timeout_r;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench: default-size loader with a stepping PC model, plus a 4-deep,
// 20-cycle-timeout instance for memory-full and timeout behaviour.
module tb_prog_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: default parameters
  logic        rst_a = 1'b1;
  logic [31:0] load_data_a = 32'd0;
  logic        load_valid_a = 1'b0;
  logic        load_last_a = 1'b0;
  logic        load_ready_a;
  logic        imem_wr_en_a;
  logic [7:0]  imem_wr_addr_a;
  logic [31:0] imem_wr_data_a;
  logic        core_rst_n_a;
  logic [31:0] core_pc_a = 32'd0;
  logic [4:0]  rf_rd_addr_a;
  logic [31:0] rf_rd_data_a;
  logic [31:0] dump_data_a;
  logic        dump_valid_a;
  logic        dump_last_a;
  logic        dump_ready_a = 1'b0;
  logic        done_a;
  logic        timeout_a;

  // Instance B: IMEM_DEPTH=4, RUN_TIMEOUT=20
  logic        rst_b = 1'b1;
  logic [31:0] load_data_b = 32'd0;
  logic        load_valid_b = 1'b0;
  logic        load_last_b = 1'b0;
  logic        load_ready_b;
  logic        imem_wr_en_b;
  logic [1:0]  imem_wr_addr_b;
  logic [31:0] imem_wr_data_b;
  logic        core_rst_n_b;
  logic [31:0] core_pc_b = 32'd0;
  logic        pc_stuck_b = 1'b1;
  logic [4:0]  rf_rd_addr_b;
  logic [31:0] rf_rd_data_b;
  logic [31:0] dump_data_b;
  logic        dump_valid_b;
  logic        dump_last_b;
  logic        dump_ready_b = 1'b0;
  logic        done_b;
  logic        timeout_b;

  logic [31:0] wq_addr_a[$];
  logic [31:0] wq_data_a[$];
  logic [31:0] dq_a[$];
  logic        dl_a[$];
  logic [31:0] wq_addr_b[$];
  logic [31:0] dq_b[$];
  logic        dl_b[$];

  prog_loader u_dut_a (
    .Clk_Core(clk), .Rst_Core(rst_a),
    .Load_Data(load_data_a), .Load_Valid(load_valid_a), .Load_Last(load_last_a),
    .Load_Ready(load_ready_a),
    .Imem_Wr_En(imem_wr_en_a), .Imem_Wr_Addr(imem_wr_addr_a), .Imem_Wr_Data(imem_wr_data_a),
    .Core_Rst_N(core_rst_n_a), .Core_PC(core_pc_a),
    .Rf_Rd_Addr(rf_rd_addr_a), .Rf_Rd_Data(rf_rd_data_a),
    .Dump_Data(dump_data_a), .Dump_Valid(dump_valid_a), .Dump_Last(dump_last_a),
    .Dump_Ready(dump_ready_a), .Done(done_a), .Timeout(timeout_a)
  );

  prog_loader #(.IMEM_DEPTH(4), .ADDR_W(2), .RST_HOLD(2), .RUN_TIMEOUT(20)) u_dut_b (
    .Clk_Core(clk), .Rst_Core(rst_b),
    .Load_Data(load_data_b), .Load_Valid(load_valid_b), .Load_Last(load_last_b),
    .Load_Ready(load_ready_b),
    .Imem_Wr_En(imem_wr_en_b), .Imem_Wr_Addr(imem_wr_addr_b), .Imem_Wr_Data(imem_wr_data_b),
    .Core_Rst_N(core_rst_n_b), .Core_PC(core_pc_b),
    .Rf_Rd_Addr(rf_rd_addr_b), .Rf_Rd_Data(rf_rd_data_b),
    .Dump_Data(dump_data_b), .Dump_Valid(dump_valid_b), .Dump_Last(dump_last_b),
    .Dump_Ready(dump_ready_b), .Done(done_b), .Timeout(timeout_b)
  );

  // Preloaded register files: xN = N*0x11
  assign rf_rd_data_a = 32'(rf_rd_addr_a) * 32'h11;
  assign rf_rd_data_b = 32'(rf_rd_addr_b) * 32'h11;

  // Core PC model: held at 0 in reset, otherwise steps one word per cycle
  always @(posedge clk) begin
    if (!core_rst_n_a) core_pc_a <= 32'd0;
    else               core_pc_a <= core_pc_a + 32'd4;
    if (!core_rst_n_b || pc_stuck_b) core_pc_b <= 32'd0;
    else                             core_pc_b <= core_pc_b + 32'd4;
  end

  // Capture write strobes and dump handshakes away from the active edge
  always @(negedge clk) begin
    if (imem_wr_en_a) begin
      wq_addr_a.push_back(32'(imem_wr_addr_a));
      wq_data_a.push_back(imem_wr_data_a);
    end
    if (dump_valid_a && dump_ready_a) begin
      dq_a.push_back(dump_data_a);
      dl_a.push_back(dump_last_a);
    end
    if (imem_wr_en_b) wq_addr_b.push_back(32'(imem_wr_addr_b));
    if (dump_valid_b && dump_ready_b) begin
      dq_b.push_back(dump_data_b);
      dl_b.push_back(dump_last_b);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_a();
    check_val("rst_ctl_a", {25'd0, load_ready_a, imem_wr_en_a, core_rst_n_a, dump_valid_a,
                            dump_last_a, done_a, timeout_a}, 32'd0);
    check_val("rst_addr_a", {19'd0, imem_wr_addr_a, rf_rd_addr_a}, 32'd0);
    check_val("rst_wdata_a", imem_wr_data_a, 32'd0);
  endtask

  task automatic pulse_reset_a();
    rst_a = 1'b1;
    load_valid_a = 1'b0;
    load_last_a = 1'b0;
    dump_ready_a = 1'b0;
    tick();
    check_reset_a();
    rst_a = 1'b0;
  endtask

  task automatic wait_ready_a();
    int t = 0;
    while (!load_ready_a && t < 10) begin
      tick();
      t++;
    end
    check_val("ready_a", 32'(load_ready_a), 32'd1);
  endtask

  task automatic load3_a(input logic [31:0] base);
    wait_ready_a();
    wq_addr_a.delete();
    wq_data_a.delete();
    for (int i = 0; i < 3; i++) begin
      load_valid_a = 1'b1;
      load_data_a = base + 32'(i);
      load_last_a = (i == 2);
      tick();
    end
    load_valid_a = 1'b0;
    load_last_a = 1'b0;
  endtask

  // Called in the first HOLD cycle; core reset stays low two cycles then rises
  task automatic release_a();
    check_val("hold1_rstn_a", 32'(core_rst_n_a), 32'd0);
    check_val("hold1_ready_a", 32'(load_ready_a), 32'd0);
    tick();
    check_val("hold2_rstn_a", 32'(core_rst_n_a), 32'd0);
    tick();
    check_val("run_rstn_a", 32'(core_rst_n_a), 32'd1);
  endtask

  task automatic check_writes_a(input logic [31:0] base);
    check_val("wr_cnt_a", 32'(wq_addr_a.size()), 32'd3);
    for (int i = 0; i < wq_addr_a.size(); i++) begin
      check_val($sformatf("wr_addr_a%0d", i), wq_addr_a[i], 32'(i));
      check_val($sformatf("wr_data_a%0d", i), wq_data_a[i], base + 32'(i));
    end
  endtask

  task automatic wait_dump_a(input int exp_len);
    int t = 0;
    while (!dump_valid_a && t < 200) begin
      tick();
      t++;
    end
    check_val("run_len_a", 32'(t), 32'(exp_len));
    check_val("dump_rstn_a", 32'(core_rst_n_a), 32'd0);
    check_val("dump_tmo_a", 32'(timeout_a), 32'd0);
  endtask

  task automatic dump_a(input bit toggle);
    int cyc = 0;
    logic [31:0] prev = 32'd0;
    bit stalled = 1'b0;
    dq_a.delete();
    dl_a.delete();
    while (!done_a && cyc < 400) begin
      if (stalled) check_val("stall_hold_a", dump_data_a, prev);
      dump_ready_a = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      stalled = dump_valid_a && !dump_ready_a;
      prev = dump_data_a;
      tick();
      cyc++;
    end
    dump_ready_a = 1'b0;
    check_val("done_a", 32'(done_a), 32'd1);
    check_val("beats_a", 32'(dq_a.size()), 32'd32);
    for (int i = 0; i < dq_a.size(); i++) begin
      check_val($sformatf("dump_x%0d_a", i), dq_a[i], 32'(i) * 32'h11);
      check_val($sformatf("last_x%0d_a", i), 32'(dl_a[i]), 32'(i == 31));
    end
    check_val("done_ctl_a", {29'd0, dump_valid_a, core_rst_n_a, timeout_a}, 32'd0);
  endtask

  task automatic load6_b();
    int t = 0;
    while (!load_ready_b && t < 10) begin
      tick();
      t++;
    end
    check_val("ready_b", 32'(load_ready_b), 32'd1);
    wq_addr_b.delete();
    for (int i = 0; i < 6; i++) begin
      load_valid_b = 1'b1;
      load_data_b = 32'hC000_0000 + 32'(i);
      load_last_b = 1'b0;
      tick();
      if (i == 3) check_val("full_ready_b", 32'(load_ready_b), 32'd0);
    end
    load_valid_b = 1'b0;
    check_val("wr_cnt_b", 32'(wq_addr_b.size()), 32'd4);
    for (int i = 0; i < wq_addr_b.size(); i++)
      check_val($sformatf("wr_addr_b%0d", i), wq_addr_b[i], 32'(i));
    check_val("run_rstn_b", 32'(core_rst_n_b), 32'd1);
  endtask

  task automatic run_len_b(input int exp_len);
    int t = 0;
    while (!dump_valid_b && t < 200) begin
      tick();
      t++;
    end
    check_val("run_len_b", 32'(t), 32'(exp_len));
  endtask

  initial begin
    logic [4:0] vpat;
    int w;
    int nlast;
    int t;

    // Reset values
    repeat (3) tick();
    check_reset_a();
    check_val("rst_ctl_b", {27'd0, load_ready_b, imem_wr_en_b, core_rst_n_b, done_b, timeout_b}, 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Gapped load 1,0,0,1,1 with Last on the third word, then toggled-ready dump
    wait_ready_a();
    wq_addr_a.delete();
    wq_data_a.delete();
    vpat = 5'b11001;
    w = 0;
    for (int i = 0; i < 5; i++) begin
      load_valid_a = vpat[i];
      load_data_a = 32'hA000_0000 + 32'(w);
      load_last_a = vpat[i] && (w == 2);
      if (vpat[i]) w++;
      tick();
    end
    load_valid_a = 1'b0;
    load_last_a = 1'b0;
    check_val("final_wr_en_a", 32'(imem_wr_en_a), 32'd1);
    check_val("final_wr_addr_a", 32'(imem_wr_addr_a), 32'd2);
    release_a();
    check_writes_a(32'hA000_0000);
    wait_dump_a(4);
    dump_a(1'b1);

    // Reset mid-RUN
    pulse_reset_a();
    load3_a(32'hB000_0000);
    release_a();
    tick();
    pulse_reset_a();

    // Fresh load after reset, then reset mid-DUMP
    load3_a(32'hD000_0000);
    release_a();
    check_writes_a(32'hD000_0000);
    wait_dump_a(4);
    dump_ready_a = 1'b1;
    tick();
    tick();
    check_val("mid_idx_a", 32'(rf_rd_addr_a), 32'd2);
    check_val("mid_data_a", dump_data_a, 32'h22);
    pulse_reset_a();

    // Clean straight load of three words and full dump
    load3_a(32'hE000_0000);
    release_a();
    check_writes_a(32'hE000_0000);
    wait_dump_a(4);
    dump_a(1'b0);

    // Memory full with PC stuck at 0: timeout after 20 RUN cycles
    pc_stuck_b = 1'b1;
    load6_b();
    run_len_b(20);
    check_val("tmo_b", 32'(timeout_b), 32'd1);
    dq_b.delete();
    dl_b.delete();
    dump_ready_b = 1'b1;
    t = 0;
    while (!done_b && t < 100) begin
      tick();
      t++;
    end
    check_val("done_b", 32'(done_b), 32'd1);
    check_val("beats_b", 32'(dq_b.size()), 32'd32);
    nlast = 0;
    foreach (dl_b[i]) if (dl_b[i]) nlast++;
    check_val("nlast_b", 32'(nlast), 32'd1);
    if (dl_b.size() > 0) begin
      check_val("last_beat_b", 32'(dl_b[dl_b.size() - 1]), 32'd1);
      check_val("last_data_b", dq_b[dq_b.size() - 1], 32'd31 * 32'h11);
    end
    dump_ready_b = 1'b0;

    // Memory full with stepping PC: target 16 reached after 5 RUN cycles
    rst_b = 1'b1;
    tick();
    check_val("rst2_ctl_b", {27'd0, load_ready_b, imem_wr_en_b, core_rst_n_b, done_b, timeout_b}, 32'd0);
    rst_b = 1'b0;
    pc_stuck_b = 1'b0;
    load6_b();
    run_len_b(5);
    check_val("no_tmo_b", 32'(timeout_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

endmodule
